bd_input_arbiter: RTL and testbench



---
 rtl/bd_input_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bd_input_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bd_input_arbiter.sv
// +----------------------------------------------------------------------------+
// | bd_input_arbiter: round-robin arbiter feeding the BD encoder word channel, |
// | holding the grant across multi-chunk serialized leaves.   Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module bd_input_arbiter #(
  parameter int NREQ     = 4,
  parameter int NCODE    = 6,
  parameter int NPAYLOAD = 20,
  parameter int NSER     = 4,
  parameter int SER_LO   = 26,
  parameter int SER_HI   = 29
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            in_v,
  input  logic [NREQ*NCODE-1:0]      in_leaf_code,
  input  logic [NREQ*NPAYLOAD-1:0]   in_payload,
  output logic [NREQ-1:0]            in_a,
  output logic                       out_v,
  output logic [NCODE-1:0]           out_leaf_code,
  output logic [NPAYLOAD-1:0]        out_payload,
  input  logic                       out_a,
  output logic [$clog2(NREQ)-1:0]    grant_idx,
  output logic                       locked
);

  localparam int IDXW = $clog2(NREQ);
  localparam int SUMW = IDXW + 1;
  localparam int CNTW = (NSER > 1) ? $clog2(NSER) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX  = IDXW'(NREQ - 1);
  localparam logic [CNTW-1:0] C_CNT_INIT  = CNTW'(NSER - 1);
  localparam logic [CNTW-1:0] C_CNT_ONE   = CNTW'(1);
  localparam logic [SUMW-1:0] C_NREQ_SUM  = SUMW'(NREQ);
  localparam logic [NCODE-1:0] C_SER_LO   = NCODE'(SER_LO);
  localparam logic [NCODE-1:0] C_SER_HI   = NCODE'(SER_HI);
  localparam bit              C_HAS_BURST = (NSER > 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  out_v_q, out_v_d;
  logic [NCODE-1:0]      out_leaf_code_q, out_leaf_code_d;
  logic [NPAYLOAD-1:0]   out_payload_q, out_payload_d;
  logic [IDXW-1:0]       grant_idx_q, grant_idx_d;
  logic [IDXW-1:0]       lock_owner_q, lock_owner_d;
  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]       chunk_cnt_q, chunk_cnt_d;

  logic                  loadable;
  logic                  found;
  logic                  grant;
  logic [IDXW-1:0]       winner;
  logic [SUMW-1:0]       cand;
  logic [NCODE-1:0]      win_code;
  logic [NPAYLOAD-1:0]   win_payload;
  logic                  win_is_ser;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
    return (idx == C_LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // While a burst is open only its owner may win, even if it is idle.
  always_comb begin
    loadable = !out_v_q || out_a;
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    if (state_q == BURST) begin
      found  = in_v[lock_owner_q];
      winner = lock_owner_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, rr_ptr_q} + SUMW'(k);
        if (cand >= C_NREQ_SUM) begin
          cand = cand - C_NREQ_SUM;
        end
        if (!found && in_v[cand[IDXW-1:0]]) begin
          found  = 1'b1;
          winner = cand[IDXW-1:0];
        end
      end
    end
    grant       = loadable && found && !reset;
    win_code    = in_leaf_code[winner*NCODE +: NCODE];
    win_payload = in_payload[winner*NPAYLOAD +: NPAYLOAD];
    win_is_ser  = (win_code >= C_SER_LO) && (win_code <= C_SER_HI);
  end

  always_comb begin
    in_a = '0;
    if (grant) begin
      in_a[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    out_v_d         = out_v_q;
    out_leaf_code_d = out_leaf_code_q;
    out_payload_d   = out_payload_q;
    grant_idx_d     = grant_idx_q;
    lock_owner_d    = lock_owner_q;
    rr_ptr_d        = rr_ptr_q;
    chunk_cnt_d     = chunk_cnt_q;

    if (grant) begin
      out_v_d         = 1'b1;
      out_leaf_code_d = win_code;
      out_payload_d   = win_payload;
      grant_idx_d     = winner;
      if (state_q == BURST) begin
        // Later chunks are forwarded without re-decoding their leaf code.
        if (chunk_cnt_q == C_CNT_ONE) begin
          state_d     = IDLE;
          chunk_cnt_d = '0;
          rr_ptr_d    = wrap_inc(lock_owner_q);
        end else begin
          chunk_cnt_d = chunk_cnt_q - C_CNT_ONE;
        end
      end else if (C_HAS_BURST && win_is_ser) begin
        state_d      = BURST;
        lock_owner_d = winner;
        chunk_cnt_d  = C_CNT_INIT;
      end else begin
        rr_ptr_d = wrap_inc(winner);
      end
    end else if (out_v_q && out_a) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      out_v_q         <= 1'b0;
      out_leaf_code_q <= '0;
      out_payload_q   <= '0;
      grant_idx_q     <= '0;
      lock_owner_q    <= '0;
      rr_ptr_q        <= '0;
      chunk_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      out_v_q         <= out_v_d;
      out_leaf_code_q <= out_leaf_code_d;
      out_payload_q   <= out_payload_d;
      grant_idx_q     <= grant_idx_d;
      lock_owner_q    <= lock_owner_d;
      rr_ptr_q        <= rr_ptr_d;
      chunk_cnt_q     <= chunk_cnt_d;
    end
  end

  assign out_v         = out_v_q;
  assign out_leaf_code = out_leaf_code_q;
  assign out_payload   = out_payload_q;
  assign grant_idx     = grant_idx_q;
  assign locked        = (state_q == BURST);

endmodule

`default_nettype wire

// File: tb/tb_bd_input_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_bd_input_arbiter: self-checking bench for bd_input_arbiter.  Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bd_input_arbiter;

  localparam int NREQ     = 4;
  localparam int NCODE    = 6;
  localparam int NPAYLOAD = 20;
  localparam int NSER     = 4;
  localparam int SER_LO   = 26;
  localparam int SER_HI   = 29;
  localparam int QD       = 256;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          in_v;
  logic [NREQ*NCODE-1:0]    in_leaf_code;
  logic [NREQ*NPAYLOAD-1:0] in_payload;
  logic [NREQ-1:0]          in_a;
  logic                     out_v;
  logic [NCODE-1:0]         out_leaf_code;
  logic [NPAYLOAD-1:0]      out_payload;
  logic                     out_a;
  logic [1:0]               grant_idx;
  logic                     locked;

  always #5 clk = ~clk;

  bd_input_arbiter #(
    .NREQ(NREQ), .NCODE(NCODE), .NPAYLOAD(NPAYLOAD),
    .NSER(NSER), .SER_LO(SER_LO), .SER_HI(SER_HI)
  ) dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_leaf_code(in_leaf_code), .in_payload(in_payload), .in_a(in_a),
    .out_v(out_v), .out_leaf_code(out_leaf_code), .out_payload(out_payload),
    .out_a(out_a), .grant_idx(grant_idx), .locked(locked)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Upstream sources: per-requester FIFOs of words, presented in order.
  logic [NCODE-1:0]    src_code [NREQ][QD];
  logic [NPAYLOAD-1:0] src_pay  [NREQ][QD];
  int                  head [NREQ];
  int                  tail [NREQ];
  logic [NREQ-1:0]     hold;
  logic [31:0]         log_q [$];

  // Reference model state.
  bit                  m_ov;
  logic [NCODE-1:0]    m_code;
  logic [NPAYLOAD-1:0] m_pay;
  int                  m_idx, m_owner, m_left, m_rr;
  bit                  m_lock;

  bit                  pok;
  int                  pw;
  logic [NCODE-1:0]    pcode;
  logic [NPAYLOAD-1:0] ppay;
  logic [NREQ-1:0]     a_s;

  typedef struct {
    logic [NREQ-1:0] v_mask;
    logic            oa;
    logic [NREQ-1:0] exp_a;
    logic            exp_ov;
    logic [1:0]      exp_gi;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ent(input int idx, input int code, input int pay);
    return {4'b0, 2'(idx), 6'(code), 20'(pay)};
  endfunction

  task automatic check_log(input string name, input int k, input logic [31:0] exp);
    if (k < log_q.size()) check(name, log_q[k], exp);
    else begin
      n_checks++;
      $display("FAIL %s: entry %0d missing, got %0d entries expected 0x%0h", name, k, log_q.size(), exp);
    end
  endtask

  task automatic push(input int i, input int code, input int pay);
    src_code[i][tail[i] % QD] = NCODE'(code);
    src_pay[i][tail[i] % QD]  = NPAYLOAD'(pay);
    tail[i]++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    hold = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i] && !hold[i]) begin
        in_v[i] = 1'b1;
        in_leaf_code[i*NCODE +: NCODE]  = src_code[i][head[i] % QD];
        in_payload[i*NPAYLOAD +: NPAYLOAD] = src_pay[i][head[i] % QD];
      end else begin
        in_v[i] = 1'b0;
        in_leaf_code[i*NCODE +: NCODE]  = '0;
        in_payload[i*NPAYLOAD +: NPAYLOAD] = '0;
      end
    end
  endtask

  task automatic predict();
    int j;
    pok = 0;
    pw  = 0;
    if (reset || (m_ov && !out_a)) return;
    if (m_lock) begin
      if (in_v[m_owner]) begin
        pok = 1;
        pw  = m_owner;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_rr + k) % NREQ;
        if (!pok && in_v[j]) begin
          pok = 1;
          pw  = j;
        end
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_ov = 0; m_code = '0; m_pay = '0; m_idx = 0;
      m_lock = 0; m_owner = 0; m_left = 0; m_rr = 0;
    end else if (pok) begin
      m_ov = 1; m_code = pcode; m_pay = ppay; m_idx = pw;
      if (m_lock) begin
        m_left--;
        if (m_left == 0) begin
          m_lock = 0;
          m_rr   = (m_owner + 1) % NREQ;
        end
      end else if (NSER > 1 && int'(pcode) >= SER_LO && int'(pcode) <= SER_HI) begin
        m_lock = 1; m_owner = pw; m_left = NSER - 1;
      end else begin
        m_rr = (pw + 1) % NREQ;
      end
    end else if (m_ov && out_a) begin
      m_ov = 0;
    end
  endtask

  task automatic tick_pre();
    logic [NREQ-1:0] exp_a;
    drive();
    #4;
    predict();
    exp_a = pok ? (NREQ'(1) << pw) : '0;
    check("in_a", 32'(in_a), 32'(exp_a));
    check("out_v", 32'(out_v), 32'(m_ov));
    check("locked", 32'(locked), 32'(m_lock));
    check("out_leaf_code", 32'(out_leaf_code), 32'(m_code));
    check("out_payload", 32'(out_payload), 32'(m_pay));
    check("grant_idx", 32'(grant_idx), 32'(m_idx));
    if (!reset && out_v && out_a) log_q.push_back({4'b0, grant_idx, out_leaf_code, out_payload});
    a_s = in_a;
    pcode = in_leaf_code[pw*NCODE +: NCODE];
    ppay  = in_payload[pw*NPAYLOAD +: NPAYLOAD];
  endtask

  task automatic tick_post();
    @(posedge clk);
    model_update();
    for (int i = 0; i < NREQ; i++) if (a_s[i]) head[i]++;
    if (reset) clear_srcs();
    #1;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic reset_tick();
    reset = 1'b1;
    clear_srcs();
    tick();
    reset = 1'b0;
    log_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    out_a = 1'b0;
    in_v = '0; in_leaf_code = '0; in_payload = '0;
    clear_srcs();
    m_ov = 0; m_code = '0; m_pay = '0; m_idx = 0;
    m_lock = 0; m_owner = 0; m_left = 0; m_rr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();  // reset state

    // Round robin, table-driven, including a stall row.
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[6] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[7] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[8] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) push(i, 30, (i << 8) | k);
    for (int r = 0; r < 9; r++) begin
      hold  = ~tbl[r].v_mask;
      out_a = tbl[r].oa;
      tick_pre();
      check("rr_in_a", 32'(in_a), 32'(tbl[r].exp_a));
      check("rr_out_v", 32'(out_v), 32'(tbl[r].exp_ov));
      check("rr_grant_idx", 32'(grant_idx), 32'(tbl[r].exp_gi));
      tick_post();
    end

    // Burst lock: req1 serialized burst, then req2 (rr_ptr=2), then req0.
    reset_tick();
    out_a = 1'b1;
    for (int k = 1; k <= 4; k++) push(1, 26, k);
    tick();
    push(0, 30, 'hA0);
    push(2, 30, 'hC0);
    repeat (10) tick();
    for (int k = 0; k < 4; k++) check_log("burst_log", k, ent(1, 26, k + 1));
    check_log("burst_log", 4, ent(2, 30, 'hC0));
    check_log("burst_log", 5, ent(0, 30, 'hA0));

    // Owner gap: no ack to anyone while the lock owner is idle.
    reset_tick();
    push(3, 28, 'h31);
    tick();
    hold[3] = 1'b1;
    for (int k = 2; k <= 4; k++) push(3, 28, 'h30 + k);
    push(0, 30, 'h0A);
    repeat (5) begin
      tick_pre();
      check("gap_in_a", 32'(in_a), 32'h0);
      tick_post();
    end
    hold[3] = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) check_log("gap_log", k, ent(3, 28, 'h31 + k));
    check_log("gap_log", 4, ent(0, 30, 'h0A));

    // Backpressure: entry held stable, then drain+load without bubble.
    reset_tick();
    out_a = 1'b0;
    push(0, 23, 'h12345);
    push(1, 30, 'h00111);
    tick();
    repeat (10) begin
      tick_pre();
      check("bp_word", {6'b0, out_leaf_code, out_payload}, {6'b0, 6'd23, 20'h12345});
      check("bp_in_a", 32'(in_a), 32'h0);
      check("bp_out_v", 32'(out_v), 32'h1);
      tick_post();
    end
    out_a = 1'b1;
    tick_pre();
    check("bp_release_in_a", 32'(in_a), 32'b0010);
    tick_post();
    tick_pre();
    check("bp_next_v", 32'(out_v), 32'h1);
    check("bp_next_payload", 32'(out_payload), 32'h00111);
    check("bp_next_idx", 32'(grant_idx), 32'h1);
    tick_post();

    // Reset in the middle of a PROG_PAT burst.
    reset_tick();
    out_a = 1'b1;
    for (int k = 1; k <= 4; k++) push(1, 27, k);
    tick();
    tick();
    reset = 1'b1;
    clear_srcs();
    tick_pre();
    check("rst_in_a", 32'(in_a), 32'h0);
    tick_post();
    reset = 1'b0;
    push(2, 30, 'h22);
    push(3, 30, 'h33);
    tick_pre();
    check("rst_out_v", 32'(out_v), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_code", 32'(out_leaf_code), 32'h0);
    check("rst_new_grant", 32'(in_a), 32'b0100);
    tick_post();
    repeat (3) tick();

    // Invalid leaf code passes through without locking.
    reset_tick();
    push(0, 40, 'h5);
    push(1, 30, 'h6);
    tick();
    tick_pre();
    check("inv_code", 32'(out_leaf_code), 32'd40);
    check("inv_locked", 32'(locked), 32'h0);
    check("inv_next_in_a", 32'(in_a), 32'b0010);
    tick_post();
    repeat (2) tick();

    // Randomized traffic against the reference model.
    reset_tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_a = ($urandom % 4) != 0;
      reset = ($urandom % 400) == 0;
      for (int i = 0; i < NREQ; i++) begin
        if (head[i] == tail[i] && ($urandom % 3) == 0) begin
          c = int'($urandom % 64);
          push(i, c, int'($urandom % (1 << NPAYLOAD)));
          if (c >= SER_LO && c <= SER_HI)
            for (int k = 1; k < NSER; k++) push(i, int'($urandom % 64), int'($urandom % (1 << NPAYLOAD)));
        end
      end
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
